// File: rtl/avalon_pkg.sv
// Shared definitions for the Avalon-MM register slave:
// wait-state FSM encoding, byte-lane count and RO counter address.
package avalon_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } ws_state_e;

    localparam int BYTE_LANES = 4;
    localparam int DATA_W     = 8 * BYTE_LANES;

    // The write counter always occupies the last mapped word.
    function automatic int ro_addr(input int num_regs);
        return num_regs - 1;
    endfunction

endpackage

// File: rtl/avalon_read_pipe.sv
// Fixed-latency read return pipe of {valid, data}.
// Ports: clk, rst_n (sync clear), i_valid/i_data in, o_valid/o_data out.
module avalon_read_pipe
    import avalon_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    logic [LATENCY-1:0] r_valid;
    logic [DATA_W-1:0]  r_data [LATENCY];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_valid[0] <= i_valid;
            r_data[0]  <= i_data;
            for (int i = 1; i < LATENCY; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_data[i]  <= r_data[i-1];
            end
        end
    end

    assign o_valid = r_valid[LATENCY-1];
    assign o_data  = r_data[LATENCY-1];

endmodule

// File: rtl/avalon_reg_slave.sv
// Avalon-MM register slave: RW bank, RO write counter, wait states,
// pipelined reads. Ports: Avalon-MM slave signals plus reg0_export.
module avalon_reg_slave
    import avalon_pkg::*;
#(
    parameter int NUM_REGS     = 4,
    parameter int ADDR_W       = 2,
    parameter int WAIT_STATES  = 1,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_W-1:0]     address,
    input  logic                  read,
    input  logic                  write,
    input  logic [BYTE_LANES-1:0] byteenable,
    input  logic [DATA_W-1:0]     writedata,
    output logic [DATA_W-1:0]     readdata,
    output logic                  readdatavalid,
    output logic                  waitrequest,
    output logic [DATA_W-1:0]     reg0_export
);

    localparam int              NRW  = NUM_REGS - 1;
    localparam logic [2:0]      WS   = 3'(WAIT_STATES);
    localparam logic [ADDR_W-1:0] RO_A = ADDR_W'(ro_addr(NUM_REGS));

    ws_state_e         r_state;
    ws_state_e         w_state_nxt;
    logic [2:0]        r_ws_cnt;
    logic [2:0]        w_ws_cnt_nxt;
    logic [DATA_W-1:0] r_regs [NRW];
    logic [DATA_W-1:0] r_wcnt;

    logic              w_req;
    logic              w_accept;
    logic              w_wr_rw;
    logic              w_rd_acc;
    logic [DATA_W-1:0] w_rdata;
    logic [DATA_W-1:0] w_push_data;

    assign w_req       = read | write;
    assign w_accept    = reset_n & w_req & (r_ws_cnt == WS);
    assign waitrequest = reset_n & w_req & (r_ws_cnt != WS);

    // Simultaneous read+write: the write wins, the read is dropped.
    assign w_wr_rw  = w_accept & write & (address < RO_A);
    assign w_rd_acc = w_accept & read & ~write;

    always_comb begin
        w_state_nxt  = r_state;
        w_ws_cnt_nxt = r_ws_cnt;
        unique case (r_state)
            IDLE: begin
                if (w_req && !w_accept) begin
                    w_state_nxt  = STALL;
                    w_ws_cnt_nxt = 3'd1;
                end
            end
            STALL: begin
                // A dropped request aborts the stall with no transfer.
                if (!w_req || w_accept) begin
                    w_state_nxt  = IDLE;
                    w_ws_cnt_nxt = '0;
                end else begin
                    w_ws_cnt_nxt = r_ws_cnt + 3'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_ws_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_ws_cnt <= w_ws_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wcnt <= '0;
            for (int i = 0; i < NRW; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_rw) begin
            r_wcnt <= r_wcnt + 1'b1;
            for (int i = 0; i < NRW; i++) begin
                if (address == ADDR_W'(i)) begin
                    for (int b = 0; b < BYTE_LANES; b++) begin
                        if (byteenable[b]) begin
                            r_regs[i][8*b +: 8] <= writedata[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        if (address == RO_A) begin
            w_rdata = r_wcnt;
        end
        for (int i = 0; i < NRW; i++) begin
            if (address == ADDR_W'(i)) begin
                w_rdata = r_regs[i];
            end
        end
    end

    assign w_push_data = w_rd_acc ? w_rdata : '0;

    avalon_read_pipe #(
        .LATENCY (READ_LATENCY)
    ) u_read_pipe (
        .clk     (clk),
        .rst_n   (reset_n),
        .i_valid (w_rd_acc),
        .i_data  (w_push_data),
        .o_valid (readdatavalid),
        .o_data  (readdata)
    );

    assign reg0_export = r_regs[0];

endmodule

// File: doc/avalon_reg_slave.md
Name: avalon_reg_slave

Overview:
- Avalon-MM slave (responder): a small 32-bit register bank that a master module reads and writes.
- Supports three features of the protocol:
  - programmable wait states on waitrequest
  - pipelined reads with a fixed latency, signalled on readdatavalid
  - per-byte writes using byteenable
- Register 0 is exported as a conduit, so the master can drive board-level logic.
- Sits on the Qsys interconnect beside the existing master interface block.

Parameters:
- NUM_REGS, 4: register count including the read-only counter; 2..16.
- ADDR_W, 2: word address width; must satisfy 2**ADDR_W >= NUM_REGS.
- WAIT_STATES, 1: waitrequest cycles inserted per transfer; 0..7.
- READ_LATENCY, 2: cycles from read acceptance to readdatavalid; 1..4.

Ports:
- clk, input, 1: single clock; all logic is on posedge.
- reset_n, input, 1: synchronous, active-low reset.
- address, input, ADDR_W: word address.
- read, input, 1: read request.
- write, input, 1: write request.
- byteenable, input, 4: byte lanes for writes; ignored on reads.
- writedata, input, 32: write data.
- readdata, output, 32: read data; meaningful only while readdatavalid=1.
- readdatavalid, output, 1: one-cycle pulse per accepted read.
- waitrequest, output, 1: stall; combinational from read, write and the wait counter.
- reg0_export, output, 32: current value of register 0.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - all registers, the wait counter and the read pipeline clear to 0.
  - readdata=0, readdatavalid=0, reg0_export=0.
  - waitrequest is 0 while reset_n=0.
  - Any in-flight read is dropped, and no readdatavalid follows.
- Register map:
  - Addresses 0..NUM_REGS-2 are RW.
  - Address NUM_REGS-1 is the RO write counter: 32-bit, counts accepted writes to RW registers, wraps from 0xFFFFFFFF to 0.
  - Addresses >= NUM_REGS read as 0; writes to them are ignored and not counted.
  - Writes to the RO address are ignored and not counted.
- Wait-state FSM, with states IDLE and STALL and a 3-bit counter ws_cnt:
  - request = read|write.
  - waitrequest = request && (ws_cnt != WAIT_STATES).
  - IDLE: on request with WAIT_STATES>0, go to STALL with ws_cnt=1. With WAIT_STATES=0 the transfer is accepted in the same cycle.
  - STALL: ws_cnt increments each cycle while the request is held. When ws_cnt==WAIT_STATES, waitrequest=0, the transfer is accepted, ws_cnt returns to 0 and the FSM returns to IDLE.
  - If request drops in STALL (master violation), return to IDLE with ws_cnt=0 and perform no transfer.
  - The master must hold address, data and byteenable stable during STALL; the slave samples them at acceptance only.
- Write at acceptance:
  - byte lane i is updated only if byteenable[i]=1.
  - byteenable=0000 still counts as a write, but no data changes.
  - The new value is visible on reg0_export on the next cycle.
- Read at acceptance:
  - the register value is sampled at that edge and pushed into a READ_LATENCY-deep valid/data shift pipe.
  - readdatavalid and readdata appear exactly READ_LATENCY cycles after the acceptance edge.
  - A new read may be accepted every (WAIT_STATES+1) cycles; the pipe supports back-to-back returns in order.
- Read and write asserted together: the write is performed, the read is discarded, and no readdatavalid is produced.
- Counter wrap and a write acceptance in the same cycle: the counter goes to 0 and the write commits.

Decomposition:
- Shared package avalon_pkg:
  - FSM state encodings (IDLE=1'b0, STALL=1'b1).
  - The byte-lane count constant (4).
  - The RO counter address expression.
- One natural sub-module, avalon_read_pipe: parameterised READ_LATENCY shift register of {valid, data[31:0]}, with synchronous active-low clear.

Test Plan:
- Reset then idle, defaults WAIT_STATES=1, READ_LATENCY=2 -> readdatavalid=0, waitrequest=0, reg0_export=0.
- Write 0xDEADBEEF to address 0 with byteenable=1111 -> waitrequest high for 1 cycle, accepted on the 2nd cycle; reg0_export=0xDEADBEEF next cycle; read of address 3 returns 1.
- Write 0x11223344 with byteenable=0101 over 0xDEADBEEF at address 1, then read address 1 -> readdatavalid exactly 2 cycles after acceptance, readdata=0xDE22BE44.
- Two reads (addresses 0 and 1) held back-to-back -> two readdatavalid pulses 2 cycles apart, in order, with the correct data.
- Write to address 3 and to an unmapped address (NUM_REGS=3 build) -> data unchanged, counter not incremented, reads return 0 for unmapped.
- reset_n low for 1 cycle one cycle after a read is accepted -> no readdatavalid, all registers 0; next transfer behaves normally.
